// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared defaults and address legality helper for the register file
package regfile_pkg;

   localparam int XLEN_DEFAULT  = 32;
   localparam int NREGS_DEFAULT = 32;

   // An address is usable when it names an existing register that is not the hard-wired zero.
   function automatic logic legal_addr(input int unsigned addr, input int unsigned nregs,
                                       input logic zero_reg);
      return (addr < nregs) && !(zero_reg && (addr == 0));
   endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// rtl/regfile_scoreboard.sv - per-register busy vector with set-over-clear priority and read masking
module regfile_scoreboard
   import regfile_pkg::*;
#(
   parameter int NREGS    = NREGS_DEFAULT,
   parameter int BYPASS   = 1,
   parameter int ZERO_REG = 1,
   parameter int AW       = $clog2(NREGS)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          wr_ok,
   input  logic [AW-1:0] waddr,
   input  logic          busy_set,
   input  logic [AW-1:0] busy_addr,
   input  logic [AW-1:0] raddr1,
   input  logic [AW-1:0] raddr2,
   output logic          busy1,
   output logic          busy2
);

   logic [NREGS-1:0] busy;
   logic             set_ok;

   assign set_ok = busy_set && legal_addr(32'(busy_addr), 32'(NREGS), ZERO_REG != 0);

   // A new producer issued in the same cycle as a commit keeps the register busy.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         busy <= '0;
      end else begin
         for (int i = 0; i < NREGS; i++) begin
            if (set_ok && (busy_addr == AW'(i)))
               busy[i] <= 1'b1;
            else if (wr_ok && (waddr == AW'(i)))
               busy[i] <= 1'b0;
         end
      end
   end

   always_comb begin
      busy1 = 1'b0;
      if (legal_addr(32'(raddr1), 32'(NREGS), ZERO_REG != 0)) begin
         busy1 = busy[raddr1];
         if ((BYPASS != 0) && wr_ok && (waddr == raddr1))
            busy1 = 1'b0;
      end
   end

   always_comb begin
      busy2 = 1'b0;
      if (legal_addr(32'(raddr2), 32'(NREGS), ZERO_REG != 0)) begin
         busy2 = busy[raddr2];
         if ((BYPASS != 0) && wr_ok && (waddr == raddr2))
            busy2 = 1'b0;
      end
   end

endmodule

// File: rtl/regfile_2r1w.sv
// rtl/regfile_2r1w.sv - two-read one-write register file with zero register, bypass and busy scoreboard
module regfile_2r1w
   import regfile_pkg::*;
#(
   parameter int XLEN     = XLEN_DEFAULT,
   parameter int NREGS    = NREGS_DEFAULT,
   parameter int BYPASS   = 1,
   parameter int ZERO_REG = 1,
   localparam int AW      = $clog2(NREGS)
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            we,
   input  logic [AW-1:0]   waddr,
   input  logic [XLEN-1:0] wdata,
   input  logic [AW-1:0]   raddr1,
   input  logic [AW-1:0]   raddr2,
   output logic [XLEN-1:0] rdata1,
   output logic [XLEN-1:0] rdata2,
   input  logic            busy_set,
   input  logic [AW-1:0]   busy_addr,
   output logic            busy1,
   output logic            busy2
);

   logic [XLEN-1:0] mem [NREGS];
   logic            wr_ok;

   // Gating with reset keeps the bypass path quiet while the array is being cleared.
   assign wr_ok = we && !reset && legal_addr(32'(waddr), 32'(NREGS), ZERO_REG != 0);

   // The zero register is never written, so its flop collapses to a constant.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < NREGS; i++)
            mem[i] <= '0;
      end else if (wr_ok) begin
         mem[waddr] <= wdata;
      end
   end

   always_comb begin
      rdata1 = '0;
      if (legal_addr(32'(raddr1), 32'(NREGS), ZERO_REG != 0)) begin
         rdata1 = mem[raddr1];
         if ((BYPASS != 0) && wr_ok && (waddr == raddr1))
            rdata1 = wdata;
      end
   end

   always_comb begin
      rdata2 = '0;
      if (legal_addr(32'(raddr2), 32'(NREGS), ZERO_REG != 0)) begin
         rdata2 = mem[raddr2];
         if ((BYPASS != 0) && wr_ok && (waddr == raddr2))
            rdata2 = wdata;
      end
   end

   regfile_scoreboard #(
      .NREGS    (NREGS),
      .BYPASS   (BYPASS),
      .ZERO_REG (ZERO_REG),
      .AW       (AW)
   ) u_scoreboard (
      .clk       (clk),
      .reset     (reset),
      .wr_ok     (wr_ok),
      .waddr     (waddr),
      .busy_set  (busy_set),
      .busy_addr (busy_addr),
      .raddr1    (raddr1),
      .raddr2    (raddr2),
      .busy1     (busy1),
      .busy2     (busy2)
   );

endmodule

// File: tb/tb_regfile_2r1w.sv
// tb/tb_regfile_2r1w.sv - directed and random checks of three register file configurations
module tb_regfile_2r1w;

   logic        clk = 1'b0;
   logic        reset;
   logic        we;
   logic [4:0]  waddr;
   logic [31:0] wdata;
   logic [4:0]  raddr1;
   logic [4:0]  raddr2;
   logic        busy_set;
   logic [4:0]  busy_addr;

   logic [31:0] rd1 [3];
   logic [31:0] rd2 [3];
   logic        b1  [3];
   logic        b2  [3];

   int checks = 0;
   int errors = 0;

   int cfg_nregs [3] = '{32, 32, 24};
   int cfg_byp   [3] = '{1, 0, 1};
   int cfg_zero  [3] = '{1, 1, 0};

   logic [31:0] m_mem  [3][32];
   logic        m_busy [3][32];

   regfile_2r1w #(.XLEN(32), .NREGS(32), .BYPASS(1), .ZERO_REG(1)) dut0 (
      .clk(clk), .reset(reset), .we(we), .waddr(waddr), .wdata(wdata),
      .raddr1(raddr1), .raddr2(raddr2), .rdata1(rd1[0]), .rdata2(rd2[0]),
      .busy_set(busy_set), .busy_addr(busy_addr), .busy1(b1[0]), .busy2(b2[0]));

   regfile_2r1w #(.XLEN(32), .NREGS(32), .BYPASS(0), .ZERO_REG(1)) dut1 (
      .clk(clk), .reset(reset), .we(we), .waddr(waddr), .wdata(wdata),
      .raddr1(raddr1), .raddr2(raddr2), .rdata1(rd1[1]), .rdata2(rd2[1]),
      .busy_set(busy_set), .busy_addr(busy_addr), .busy1(b1[1]), .busy2(b2[1]));

   regfile_2r1w #(.XLEN(32), .NREGS(24), .BYPASS(1), .ZERO_REG(0)) dut2 (
      .clk(clk), .reset(reset), .we(we), .waddr(waddr), .wdata(wdata),
      .raddr1(raddr1), .raddr2(raddr2), .rdata1(rd1[2]), .rdata2(rd2[2]),
      .busy_set(busy_set), .busy_addr(busy_addr), .busy1(b1[2]), .busy2(b2[2]));

   always #5 clk = ~clk;

   function automatic logic legal(int c, int a);
      return (a < cfg_nregs[c]) && !((cfg_zero[c] != 0) && (a == 0));
   endfunction

   function automatic logic wr_live(int c);
      return we && !reset && legal(c, int'(waddr));
   endfunction

   function automatic logic [31:0] exp_rd(int c, int a);
      if (reset || !legal(c, a)) return 32'h0;
      if ((cfg_byp[c] != 0) && wr_live(c) && (int'(waddr) == a)) return wdata;
      return m_mem[c][a];
   endfunction

   function automatic logic exp_busy(int c, int a);
      if (reset || !legal(c, a)) return 1'b0;
      if ((cfg_byp[c] != 0) && wr_live(c) && (int'(waddr) == a)) return 1'b0;
      return m_busy[c][a];
   endfunction

   task automatic model_reset();
      for (int c = 0; c < 3; c++)
         for (int a = 0; a < 32; a++) begin
            m_mem[c][a]  = 32'h0;
            m_busy[c][a] = 1'b0;
         end
   endtask

   task automatic model_edge();
      for (int c = 0; c < 3; c++) begin
         if (wr_live(c)) begin
            m_mem[c][waddr]  = wdata;
            m_busy[c][waddr] = 1'b0;
         end
         if (busy_set && legal(c, int'(busy_addr)))
            m_busy[c][busy_addr] = 1'b1;
      end
   endtask

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic check_ports(input string tag);
      #1;
      for (int c = 0; c < 3; c++) begin
         check_val($sformatf("%s cfg%0d rdata1", tag, c), rd1[c], exp_rd(c, int'(raddr1)));
         check_val($sformatf("%s cfg%0d rdata2", tag, c), rd2[c], exp_rd(c, int'(raddr2)));
         check_val($sformatf("%s cfg%0d busy1", tag, c), {31'b0, b1[c]}, {31'b0, exp_busy(c, int'(raddr1))});
         check_val($sformatf("%s cfg%0d busy2", tag, c), {31'b0, b2[c]}, {31'b0, exp_busy(c, int'(raddr2))});
      end
   endtask

   task automatic tick();
      @(posedge clk);
      if (!reset) model_edge();
      @(negedge clk);
   endtask

   task automatic idle();
      we = 1'b0;
      busy_set = 1'b0;
   endtask

   initial begin
      reset = 1'b1; we = 1'b0; waddr = '0; wdata = '0; raddr1 = '0; raddr2 = '0;
      busy_set = 1'b0; busy_addr = '0;
      model_reset();
      @(negedge clk);
      for (int a = 0; a < 32; a++) begin
         raddr1 = 5'(a); raddr2 = 5'(31 - a);
         check_ports("reset read");
      end
      reset = 1'b0;

      // fill every register, then read back on both ports
      for (int i = 0; i < 32; i++) begin
         we = 1'b1; waddr = 5'(i); wdata = 32'hA5A5_0000 + 32'(i);
         raddr1 = 5'(i); raddr2 = 5'((i + 1) % 32);
         check_ports("fill");
         tick();
      end
      idle();
      for (int a = 0; a < 32; a++) begin
         raddr1 = 5'(a); raddr2 = 5'(a);
         check_ports("readback");
      end
      raddr1 = 5'd17; raddr2 = 5'd0;
      #1;
      check_val("direct reg17", rd1[0], 32'hA5A5_0011);
      check_val("direct reg0", rd2[0], 32'h0);

      // same-cycle bypass
      we = 1'b1; waddr = 5'd5; wdata = 32'hDEAD_BEEF; raddr1 = 5'd5; raddr2 = 5'd5;
      check_ports("bypass");
      check_val("bypass on rd1", rd1[0], 32'hDEAD_BEEF);
      check_val("bypass on rd2", rd2[0], 32'hDEAD_BEEF);
      check_val("no bypass old", rd1[1], 32'hA5A5_0005);
      tick();
      idle();
      check_ports("after bypass");
      check_val("no bypass new", rd2[1], 32'hDEAD_BEEF);

      // scoreboard sequence on register 7
      busy_set = 1'b1; busy_addr = 5'd7; raddr1 = 5'd7; raddr2 = 5'd7;
      check_ports("busy set cycle");
      tick();
      idle();
      check_ports("busy visible");
      check_val("busy7 set", {31'b0, b1[0]}, 32'd1);
      we = 1'b1; waddr = 5'd7; wdata = 32'h0000_7777;
      check_ports("busy write cycle");
      check_val("busy7 bypass clear", {31'b0, b1[0]}, 32'd0);
      check_val("busy7 no bypass", {31'b0, b1[1]}, 32'd1);
      tick();
      idle();
      check_ports("busy cleared");
      check_val("busy7 after write", {31'b0, b2[1]}, 32'd0);
      busy_set = 1'b1; busy_addr = 5'd7; we = 1'b1; waddr = 5'd7; wdata = 32'h1234_5678;
      check_ports("set and write");
      tick();
      idle();
      check_ports("set wins");
      check_val("set wins busy", {31'b0, b1[0]}, 32'd1);
      check_val("set wins data", rd1[0], 32'h1234_5678);

      // zero register and out-of-range address
      we = 1'b1; waddr = 5'd0; wdata = 32'h0000_1234; busy_set = 1'b1; busy_addr = 5'd0;
      raddr1 = 5'd0; raddr2 = 5'd0;
      check_ports("zero write");
      tick();
      idle();
      check_ports("zero after");
      check_val("zero reg data", rd1[0], 32'h0);
      check_val("zero reg busy", {31'b0, b1[0]}, 32'd0);
      check_val("reg0 writable", rd1[2], 32'h0000_1234);
      we = 1'b1; waddr = 5'd30; wdata = 32'h0000_CAFE; busy_set = 1'b1; busy_addr = 5'd30;
      raddr1 = 5'd30; raddr2 = 5'd30;
      check_ports("addr30 write");
      tick();
      idle();
      check_ports("addr30 after");
      check_val("addr30 nregs24", rd1[2], 32'h0);
      check_val("addr30 busy24", {31'b0, b1[2]}, 32'd0);
      check_val("addr30 nregs32", rd1[0], 32'h0000_CAFE);

      // asynchronous reset arriving mid-cycle with a write in flight
      we = 1'b1; waddr = 5'd3; wdata = 32'hFFFF_FFFF; busy_set = 1'b1; busy_addr = 5'd3;
      tick();
      busy_set = 1'b0; waddr = 5'd4; wdata = 32'h0BAD_F00D; raddr1 = 5'd3; raddr2 = 5'd4;
      check_ports("pre reset");
      #2;
      reset = 1'b1;
      model_reset();
      check_ports("mid reset");
      check_val("reset reg3", rd1[0], 32'h0);
      check_val("reset busy3", {31'b0, b1[0]}, 32'd0);
      @(posedge clk);
      @(negedge clk);
      we = 1'b0;
      reset = 1'b0;
      check_ports("post reset");
      check_val("reg4 dropped", rd2[0], 32'h0);

      // randomized traffic
      for (int n = 0; n < 400; n++) begin
         we = 1'($urandom_range(0, 1));
         waddr = 5'($urandom_range(0, 31));
         wdata = $urandom;
         busy_set = 1'($urandom_range(0, 1));
         busy_addr = ($urandom_range(0, 3) == 0) ? waddr : 5'($urandom_range(0, 31));
         raddr1 = ($urandom_range(0, 3) == 0) ? waddr : 5'($urandom_range(0, 31));
         raddr2 = ($urandom_range(0, 3) == 0) ? raddr1 : 5'($urandom_range(0, 31));
         check_ports("random");
         tick();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/regfile_2r1w.md
# regfile_2r1w

Parametrised register file for the RISC-V core: two combinational read ports, one synchronous write port, hard-wired zero register, optional write-to-read bypass, and a per-register busy scoreboard. It replaces the single-read, one-hot-enable register file in the decode/writeback path. Decode reads rs1/rs2 and their busy state. Writeback commits rd and clears its busy bit.

## Interface
Parameters:
- XLEN, 32, data width in bits
- NREGS, 32, number of architectural registers (2..32, need not be a power of two)
- BYPASS, 1, 1 = same-cycle write data is forwarded to matching read ports
- ZERO_REG, 1, 1 = register 0 reads as zero and ignores writes and busy sets
- AW (localparam), $clog2(NREGS), address width

Ports:
- clk  in  1  clock, rising-edge
- reset  in  1  asynchronous, active-high; clears all registers and busy bits
- we  in  1  write enable
- waddr  in  AW  write address
- wdata  in  XLEN  write data
- raddr1  in  AW  read port 1 address
- raddr2  in  AW  read port 2 address
- rdata1  out  XLEN  read port 1 data
- rdata2  out  XLEN  read port 2 data
- busy_set  in  1  mark busy_addr as having an in-flight producer
- busy_addr  in  AW  register to mark busy
- busy1  out  1  raddr1 has a pending write
- busy2  out  1  raddr2 has a pending write

## Operation
- Storage: NREGS x XLEN flops (reg[0] omitted when ZERO_REG=1). Busy vector: NREGS bits.
- Write: on the rising edge with we=1, reg[waddr] <= wdata.
  - Ignored when waddr >= NREGS.
  - Ignored when waddr==0 and ZERO_REG=1.
- Read: rdataN = reg[raddrN], combinational.
  - Returns 0 for raddrN >= NREGS.
  - Returns 0 for raddrN==0 when ZERO_REG=1.
- Bypass (BYPASS=1): if we && waddr==raddrN && the write is legal, then rdataN = wdata in the same cycle. With BYPASS=0, the old value is returned until the edge.
- Busy set: busy_set=1 sets busy[busy_addr] at the edge. Ignored for an illegal address.
- Busy clear: a legal write clears busy[waddr] at the edge.
- Simultaneous set and write to the same address: set wins, and busy stays 1 (a new producer was issued). Data is still written.
- Busy outputs: busyN = busy[raddrN] & ~(BYPASS & legal write to raddrN this cycle). busyN is always 0 for illegal/zero addresses.
- Both read ports may carry the same address. Both outputs then match.

## Timing
- Reset (asynchronous assert, synchronous-safe deassert handled upstream): all regs = 0, all busy = 0. Outputs during reset are rdata1 = rdata2 = 0 and busy1 = busy2 = 0.
- Reset asserted mid-cycle overrides a concurrent write or busy_set.
- Write latency: 1 edge to be architecturally visible. With BYPASS=1, read-after-write has zero cycles of latency.
- busy_set to busyN visible: next cycle.
- Write to busy cleared: next cycle (same cycle on busyN when BYPASS=1).
- There is no handshake and no stall; every cycle accepts one write and one busy_set.

## Structure
- Shared package regfile_pkg:
  - XLEN_DEFAULT
  - NREGS_DEFAULT
  - function legal_addr(addr, nregs, zero_reg)
- Sub-module regfile_scoreboard: holds the busy vector, set/clear priority, and the busyN outputs with bypass masking.
- Top-level: storage, read mux, and bypass.

## Test plan
- Reset then read all addresses: every rdata is 0 and every busy is 0. Then write 0xA5A5_0000+i to each reg i in sequence. Read back via both ports: reg0 = 0 (ZERO_REG=1), and regs 1..31 match.
- BYPASS=1, we=1, waddr=5, wdata=0xDEADBEEF, raddr1=raddr2=5 in the same cycle: both rdata = 0xDEADBEEF before the edge. With BYPASS=0, both show the old value until the next cycle.
- Scoreboard sequence:
  - busy_set on addr 7 makes busy1=1 on raddr1=7 next cycle.
  - A write to 7 with BYPASS=1 gives busy1=0 in the write cycle, and busy stays 0 after.
  - busy_set and a write to 7 in the same cycle give busy=1 afterwards, with the data written.
- Write 0x1234 to reg 0 and busy_set addr 0: rdata=0 and busy=0. For NREGS=24, a write to addr 30 is ignored and a read of 30 returns 0.
- Write 0xFFFF_FFFF to reg 3, set busy 3, then assert reset mid-cycle while a write to reg 4 is in flight: everything reads 0 immediately, and reg 4 stays 0 after reset release.
